// File: rtl/mac_stream_checker_if.sv
// Valid/ready operand stream feeding the MAC stream checker: one multiplicand/multiplier
// pair plus carry-in and end-of-run marker per transfer.
interface mac_stream_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_last;

    modport master (output in_valid, in_a, in_b, in_cin, in_last, input in_ready);
    modport slave  (input in_valid, in_a, in_b, in_cin, in_last, output in_ready);
endinterface

// File: rtl/mac_stream_checker.sv
// Operand driver and result checker for the 8-bit MAC: buffers operand pairs, feeds the MAC,
// and scores every MAC result against a golden accumulator.
module mac_stream_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAC_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    mac_stream_checker_if.slave stream,
    output logic [7:0]          mac_a,
    output logic [7:0]          mac_b,
    output logic                mac_cin,
    output logic                mac_rst,
    input  logic [15:0]         mac_out,
    input  logic                mac_cout,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    first_fail,
    output logic [15:0]         exp_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
    state_t state, next_state;

    logic [17:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;
    logic [17:0]      head;
    logic [7:0]       head_a, head_b;
    logic             head_cin, head_last;
    logic [15:0]      prod;
    logic [16:0]      sum17;
    logic [15:0]      acc;
    logic [MAC_LAT:0] tok_v;
    logic [16:0]      tok_d [MAC_LAT+1];
    logic             cmp_valid, match;

    assign full            = (count == DEPTH_V);
    assign empty           = (count == '0);
    assign stream.in_ready = !full;
    assign push            = stream.in_valid && !full;
    assign pop             = (state == RUN) && !empty;

    assign head      = fifo_mem[rd_ptr];
    assign head_last = head[17];
    assign head_cin  = head[16];
    assign head_a    = head[15:8];
    assign head_b    = head[7:0];
    assign prod      = 16'(head_a) * 16'(head_b);
    assign sum17     = {1'b0, acc} + {1'b0, prod} + {16'b0, head_cin};

    assign mac_rst = rst | (state == CLEAR);
    assign busy    = (state == CLEAR) || (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);

    // Token stage 0 is loaded on the same edge as mac_a/b/cin, so the last stage lines up
    // with the MAC result MAC_LAT edges later.
    assign cmp_valid = tok_v[MAC_LAT];
    assign match     = ({mac_cout, mac_out} == tok_d[MAC_LAT]);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {stream.in_last, stream.in_cin, stream.in_a, stream.in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_v <= '0;
            for (int i = 0; i <= MAC_LAT; i++) tok_d[i] <= '0;
        end else begin
            tok_v    <= {tok_v[MAC_LAT-1:0], pop};
            tok_d[0] <= sum17;
            for (int i = 1; i <= MAC_LAT; i++) tok_d[i] <= tok_d[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = RUN;
            RUN:     if (pop && head_last) next_state = DRAIN;
            DRAIN:   if (tok_v == '0) next_state = DONE;
            DONE:    if (start) next_state = CLEAR;
            default: next_state = IDLE;
        endcase
    end

    // Golden accumulator, MAC operand registers and scoreboard counters (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_cin    <= 1'b0;
            err        <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '0;
            exp_out    <= '0;
        end else begin
            mac_a   <= pop ? head_a : 8'd0;
            mac_b   <= pop ? head_b : 8'd0;
            mac_cin <= pop & head_cin;
            if (state == CLEAR) begin
                acc        <= '0;
                err        <= 1'b0;
                pass_count <= '0;
                fail_count <= '0;
                first_fail <= '0;
            end else begin
                if (pop) acc <= sum17[15:0];
                if (cmp_valid) begin
                    exp_out <= tok_d[MAC_LAT][15:0];
                    if (match) begin
                        if (pass_count != '1) pass_count <= pass_count + 1'b1;
                    end else begin
                        if (fail_count != '1) fail_count <= fail_count + 1'b1;
                        if (!err) first_fail <= pass_count + fail_count;
                        err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
